// File: rtl/seqgen_pkg.sv
// Shared state codes and default sizing for the sequence generator and detector blocks.
// Bench monitors decode stat through state_t.
package seqgen_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int LEN_W_DEF = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/seqgen_tx_if.sv
// Parallel-load / serial-out bus of seqgen_tx. Master drives the pattern, slave is the transmitter.
// rpt exists only when SEQGEN_REPEAT_EN is defined.
interface seqgen_tx_if
   import seqgen_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int LEN_W = LEN_W_DEF
);
   logic             start;
   logic [WIDTH-1:0] pat;
   logic [LEN_W-1:0] len;
`ifdef SEQGEN_REPEAT_EN
   logic             rpt;
`endif
   logic             dout;
   logic             dvld;
   logic             busy;
   logic             done;
   logic [1:0]       stat;

   modport master (
      output start, pat, len,
`ifdef SEQGEN_REPEAT_EN
      output rpt,
`endif
      input  dout, dvld, busy, done, stat
   );

   modport slave (
      input  start, pat, len,
`ifdef SEQGEN_REPEAT_EN
      input  rpt,
`endif
      output dout, dvld, busy, done, stat
   );
endinterface

// File: rtl/seqgen_shreg.sv
// Left-aligning loadable shift register with a bit down-counter.
// len is clamped to WIDTH-1 so the MSB always holds the first bit to send.
module seqgen_shreg #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 3
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data,
   input  logic [LEN_W-1:0] len,
   output logic             msb,
   output logic             zero
);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH - 1);

   logic [WIDTH-1:0] sreg;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] len_c;
   logic [LEN_W-1:0] sh;

   always_comb begin
      len_c = (len > LEN_MAX) ? LEN_MAX : len;
      sh    = LEN_MAX - len_c;
   end

   // Zero fill means the register is empty once the last bit has left,
   // so msb drives the line low in DONE and IDLE without extra gating.
   always_ff @(posedge clk) begin
      if (clr) begin
         sreg <= '0;
         cnt  <= '0;
      end else if (load) begin
         sreg <= data << sh;
         cnt  <= len_c;
      end else if (shift) begin
         sreg <= sreg << 1;
         if (!zero) cnt <= cnt - 1'b1;
      end
   end

   assign msb  = sreg[WIDTH-1];
   assign zero = (cnt == '0);
endmodule

// File: rtl/seqgen_tx.sv
// Serial bit-sequence transmitter, MSB-first, one bit per clock, all outputs registered.
// Optional SEQGEN_REPEAT_EN adds rpt: back-to-back replay of the captured pattern.
//
// state | meaning
// IDLE  | line low, waiting for start
// SHIFT | dout carries a pattern bit, dvld high
// DONE  | one-cycle done pulse, then IDLE
module seqgen_tx
   import seqgen_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input logic        clk,
   input logic        clr,
   seqgen_tx_if.slave bus
);
   state_t           state, state_nx;
   logic             load, shift, msb, zero;
   logic [WIDTH-1:0] ld_data;
   logic [LEN_W-1:0] ld_len;
   logic             dvld_q, busy_q, done_q;

`ifdef SEQGEN_REPEAT_EN
   logic [WIDTH-1:0] pat_hold;
   logic [LEN_W-1:0] len_hold;

   always_ff @(posedge clk) begin
      if (clr) begin
         pat_hold <= '0;
         len_hold <= '0;
      end else if (state == IDLE && bus.start) begin
         pat_hold <= bus.pat;
         len_hold <= bus.len;
      end
   end
`endif

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      shift    = 1'b0;
      ld_data  = bus.pat;
      ld_len   = bus.len;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load     = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            shift = 1'b1;
            if (zero) begin
`ifdef SEQGEN_REPEAT_EN
               if (bus.rpt) begin
                  load    = 1'b1;
                  ld_data = pat_hold;
                  ld_len  = len_hold;
               end else begin
                  state_nx = DONE;
               end
`else
               state_nx = DONE;
`endif
            end
         end
         DONE: state_nx = IDLE;
         default: begin
            // Unused code: flush the datapath on the way back to IDLE.
            state_nx = IDLE;
            load     = 1'b1;
            ld_data  = '0;
            ld_len   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state  <= IDLE;
         dvld_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nx;
         dvld_q <= (state_nx == SHIFT);
         busy_q <= (state_nx == SHIFT) || (state_nx == DONE);
         done_q <= (state_nx == DONE);
      end
   end

   seqgen_shreg #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_shreg (
      .clk   (clk),
      .clr   (clr),
      .load  (load),
      .shift (shift),
      .data  (ld_data),
      .len   (ld_len),
      .msb   (msb),
      .zero  (zero)
   );

   assign bus.dout = msb;
   assign bus.dvld = dvld_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.stat = state;
endmodule

// File: tb/tb_seqgen_tx.sv
// Directed bench for seqgen_tx: cycle table on an 8-bit instance plus hand sequences
// for done latency and len clamping on a 4-bit instance. Honours SEQGEN_REPEAT_EN.
module tb_seqgen_tx;
   import seqgen_pkg::*;

   localparam logic [5:0] O_IDLE = 6'b0_0_0_0_00;
   localparam logic [5:0] O_DONE = 6'b0_0_1_1_10;

   typedef struct {
      logic       clr;
      logic       start;
      logic [7:0] pat;
      logic [2:0] len;
      logic       rpt;
      logic [5:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic clr, clr4;
   int   n_chk = 0;
   int   n_fail = 0;
   vec_t vq[$];

   always #5 clk = ~clk;

   seqgen_tx_if #(.WIDTH(8), .LEN_W(3)) bus ();
   seqgen_tx_if #(.WIDTH(4), .LEN_W(3)) bus4 ();

   seqgen_tx #(.WIDTH(8), .LEN_W(3)) dut (.clk(clk), .clr(clr), .bus(bus));
   seqgen_tx #(.WIDTH(4), .LEN_W(3)) dut4 (.clk(clk), .clr(clr4), .bus(bus4));

   // {dout, dvld, busy, done, stat} while shifting bit b
   function automatic logic [5:0] s(input logic b);
      return {b, 1'b1, 1'b1, 1'b0, 2'b01};
   endfunction

   function automatic void add(input logic c, input logic st, input logic [7:0] p,
                               input logic [2:0] l, input logic r, input logic [5:0] e);
      vec_t v;
      v.clr = c; v.start = st; v.pat = p; v.len = l; v.rpt = r; v.exp = e;
      vq.push_back(v);
   endfunction

   function automatic logic [5:0] obs();
      return {bus.dout, bus.dvld, bus.busy, bus.done, bus.stat};
   endfunction

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   initial begin
      logic [3:0] bits4;
      int         cyc;

      clr = 1'b1; clr4 = 1'b1;
      bus.start = 1'b0; bus.pat = '0; bus.len = '0;
      bus4.start = 1'b0; bus4.pat = '0; bus4.len = '0;
`ifdef SEQGEN_REPEAT_EN
      bus.rpt = 1'b0; bus4.rpt = 1'b0;
`endif

      // reset held two edges with start high
      add(1, 1, 8'hFF, 3'd7, 0, O_IDLE);
      add(1, 1, 8'hFF, 3'd7, 0, O_IDLE);
      add(0, 0, 8'h00, 3'd0, 0, O_IDLE);
      // basic 5-bit: 1,0,0,1,0
      add(0, 1, 8'h12, 3'd4, 0, s(1));
      add(0, 0, 8'h00, 3'd0, 0, s(0));
      add(0, 0, 8'h00, 3'd0, 0, s(0));
      add(0, 0, 8'h00, 3'd0, 0, s(1));
      add(0, 0, 8'h00, 3'd0, 0, s(0));
      add(0, 0, 8'h00, 3'd0, 0, O_DONE);
      add(0, 0, 8'h00, 3'd0, 0, O_IDLE);
      // single bit
      add(0, 1, 8'h01, 3'd0, 0, s(1));
      add(0, 0, 8'h00, 3'd0, 0, O_DONE);
      add(0, 0, 8'h00, 3'd0, 0, O_IDLE);
      // start during SHIFT ignored: A5 -> 1,0,1,0,0,1,0,1
      add(0, 1, 8'hA5, 3'd7, 0, s(1));
      add(0, 1, 8'hFF, 3'd3, 0, s(0));
      add(0, 1, 8'hFF, 3'd3, 0, s(1));
      add(0, 0, 8'h00, 3'd0, 0, s(0));
      add(0, 0, 8'h00, 3'd0, 0, s(0));
      add(0, 0, 8'h00, 3'd0, 0, s(1));
      add(0, 0, 8'h00, 3'd0, 0, s(0));
      add(0, 0, 8'h00, 3'd0, 0, s(1));
      add(0, 0, 8'h00, 3'd0, 0, O_DONE);
      add(0, 0, 8'h00, 3'd0, 0, O_IDLE);
      // abort after 2nd bit, clr beats start
      add(0, 1, 8'hC3, 3'd7, 0, s(1));
      add(0, 0, 8'h00, 3'd0, 0, s(1));
      add(1, 1, 8'hFF, 3'd7, 0, O_IDLE);
      add(0, 0, 8'h00, 3'd0, 0, O_IDLE);
      add(0, 0, 8'h00, 3'd0, 0, O_IDLE);
      // back-to-back: start in DONE ignored, accepted in following IDLE
      add(0, 1, 8'h02, 3'd1, 0, s(1));
      add(0, 0, 8'h00, 3'd0, 0, s(0));
      add(0, 1, 8'h01, 3'd1, 0, O_DONE);
      add(0, 1, 8'h01, 3'd1, 0, O_IDLE);
      add(0, 1, 8'h01, 3'd1, 0, s(0));
      add(0, 0, 8'h00, 3'd0, 0, s(1));
      add(0, 0, 8'h00, 3'd0, 0, O_DONE);
      add(0, 0, 8'h00, 3'd0, 0, O_IDLE);
`ifdef SEQGEN_REPEAT_EN
      // two contiguous passes of 101, done only after rpt drops
      add(0, 1, 8'h05, 3'd2, 0, s(1));
      add(0, 0, 8'h00, 3'd0, 1, s(0));
      add(0, 0, 8'h00, 3'd0, 1, s(1));
      add(0, 0, 8'h00, 3'd0, 1, s(1));
      add(0, 0, 8'h00, 3'd0, 1, s(0));
      add(0, 0, 8'h00, 3'd0, 1, s(1));
      add(0, 0, 8'h00, 3'd0, 0, O_DONE);
      add(0, 0, 8'h00, 3'd0, 0, O_IDLE);
`endif

      for (int i = 0; i < vq.size(); i++) begin
         clr       = vq[i].clr;
         bus.start = vq[i].start;
         bus.pat   = vq[i].pat;
         bus.len   = vq[i].len;
`ifdef SEQGEN_REPEAT_EN
         bus.rpt   = vq[i].rpt;
`endif
         @(posedge clk);
         #1;
         check($sformatf("vec[%0d]", i), obs(), vq[i].exp);
      end

      // done latency for a full 8-bit pattern: len+1 edges after the start edge
      bus.start = 1'b1; bus.pat = 8'hFF; bus.len = 3'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("lat_first", obs(), s(1));
      cyc = 0;
      while (cyc < 20 && bus.done !== 1'b1) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("lat_done_edges", 6'(cyc), 6'd8);
      @(posedge clk);
      #1;
      check("lat_idle", obs(), O_IDLE);

      // len clamp on a 4-bit instance: len=7 behaves as len=3
      clr4 = 1'b0;
      check("w4_reset", {bus4.dout, bus4.dvld, bus4.busy, bus4.done, bus4.stat}, O_IDLE);
      bus4.start = 1'b1; bus4.pat = 4'b1011; bus4.len = 3'd7;
      bits4 = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         bus4.start = 1'b0;
         check($sformatf("w4_bit[%0d]", i),
               {bus4.dout, bus4.dvld, bus4.busy, bus4.done, bus4.stat}, s(bits4[3-i]));
      end
      @(posedge clk);
      #1;
      check("w4_done", {bus4.dout, bus4.dvld, bus4.busy, bus4.done, bus4.stat}, O_DONE);
      @(posedge clk);
      #1;
      check("w4_idle", {bus4.dout, bus4.dvld, bus4.busy, bus4.done, bus4.stat}, O_IDLE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
